// File: rtl/parking_occupancy_ctrl.sv
// Multi-gate parking occupancy controller: one direction-detecting FSM per gate
// feeding a shared, saturating occupancy count with full/empty/overflow/underflow.
module parking_occupancy_ctrl #(
    parameter int unsigned GATES    = 2,
    parameter int unsigned CAP_BITS = 8,
    parameter int unsigned CAPACITY = 200
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [GATES-1:0]    a,
    input  logic [GATES-1:0]    b,
    output logic [CAP_BITS-1:0] count,
    output logic                full,
    output logic                empty,
    output logic [GATES-1:0]    enter_pulse,
    output logic [GATES-1:0]    exit_pulse,
    output logic                overflow,
    output logic                underflow
);

    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, WAIT} state_t;

    // Intermediate is wide enough for count + GATES and keeps its MSB as the sign.
    localparam int unsigned     SW    = (CAP_BITS + 2 > 6) ? CAP_BITS + 2 : 6;
    localparam logic [SW-1:0]   CAP_W = SW'(CAPACITY);

    state_t              state_q [GATES];
    state_t              state_d [GATES];
    logic [GATES-1:0]    enter_d, enter_q, exit_d, exit_q;
    logic [CAP_BITS-1:0] count_d, count_q;
    logic                ovf_d, ovf_q, unf_d, unf_q;
    logic [SW-1:0]       n_ent, n_ext, next_s;

    always_comb begin
        for (int unsigned g = 0; g < GATES; g++) begin
            state_d[g] = state_q[g];
            enter_d[g] = 1'b0;
            exit_d[g]  = 1'b0;
            case (state_q[g])
                IDLE: case ({a[g], b[g]})
                    2'b10:   state_d[g] = E1;
                    2'b01:   state_d[g] = X1;
                    2'b11:   state_d[g] = WAIT;
                    default: state_d[g] = IDLE;
                endcase
                E1: case ({a[g], b[g]})
                    2'b11:   state_d[g] = E2;
                    2'b00:   state_d[g] = IDLE;
                    2'b01:   state_d[g] = WAIT;
                    default: state_d[g] = E1;
                endcase
                E2: case ({a[g], b[g]})
                    2'b01:   state_d[g] = E3;
                    2'b10:   state_d[g] = E1;
                    2'b00:   state_d[g] = IDLE;
                    default: state_d[g] = E2;
                endcase
                E3: case ({a[g], b[g]})
                    2'b00: begin
                        state_d[g] = IDLE;
                        enter_d[g] = 1'b1;
                    end
                    2'b11:   state_d[g] = E2;
                    2'b10:   state_d[g] = WAIT;
                    default: state_d[g] = E3;
                endcase
                X1: case ({a[g], b[g]})
                    2'b11:   state_d[g] = X2;
                    2'b00:   state_d[g] = IDLE;
                    2'b10:   state_d[g] = WAIT;
                    default: state_d[g] = X1;
                endcase
                X2: case ({a[g], b[g]})
                    2'b10:   state_d[g] = X3;
                    2'b01:   state_d[g] = X1;
                    2'b00:   state_d[g] = IDLE;
                    default: state_d[g] = X2;
                endcase
                X3: case ({a[g], b[g]})
                    2'b00: begin
                        state_d[g] = IDLE;
                        exit_d[g]  = 1'b1;
                    end
                    2'b11:   state_d[g] = X2;
                    2'b01:   state_d[g] = WAIT;
                    default: state_d[g] = X3;
                endcase
                default: state_d[g] = ({a[g], b[g]} == 2'b00) ? IDLE : WAIT;
            endcase
        end
    end

    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int unsigned g = 0; g < GATES; g++) begin
            n_ent = n_ent + SW'(enter_d[g]);
            n_ext = n_ext + SW'(exit_d[g]);
        end
        next_s  = SW'(count_q) + n_ent - n_ext;
        count_d = next_s[CAP_BITS-1:0];
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (next_s[SW-1]) begin
            count_d = '0;
            unf_d   = 1'b1;
        end else if (next_s > CAP_W) begin
            count_d = CAP_W[CAP_BITS-1:0];
            ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned g = 0; g < GATES; g++) state_q[g] <= IDLE;
            enter_q <= '0;
            exit_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            for (int unsigned g = 0; g < GATES; g++) state_q[g] <= state_d[g];
            enter_q <= enter_d;
            exit_q  <= exit_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count       = count_q;
    assign full        = (count_q == CAP_W[CAP_BITS-1:0]);
    assign empty       = (count_q == '0);
    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Bench for parking_occupancy_ctrl: a 4-gate/cap-200 and a 2-gate/cap-3 instance
// checked against a direction/depth behavioural model of the gate rules.
module tb_parking_occupancy_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [1:0] a2 = '0, b2 = '0;

    logic [7:0] cnt4;
    logic       full4, empty4, ov4, un4;
    logic [3:0] ep4, xp4;
    logic [3:0] cnt2;
    logic       full2, empty2, ov2, un2;
    logic [1:0] ep2, xp2;

    int total = 0;
    int bad   = 0;

    // Model: dir 0=idle 1=entering 2=exiting 3=wait; dep = progress along the path.
    int         mdir [2][4];
    int         mdep [2][4];
    int         mcount [2];
    logic [3:0] ment [2];
    logic [3:0] mext [2];
    logic       mov [2];
    logic       mun [2];
    int         cap [2] = '{200, 3};
    int         ng  [2] = '{4, 2};

    parking_occupancy_ctrl #(.GATES(4), .CAP_BITS(8), .CAPACITY(200)) dut4 (
        .clk(clk), .reset_n(reset_n), .a(a4), .b(b4), .count(cnt4), .full(full4),
        .empty(empty4), .enter_pulse(ep4), .exit_pulse(xp4), .overflow(ov4), .underflow(un4));

    parking_occupancy_ctrl #(.GATES(2), .CAP_BITS(4), .CAPACITY(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .a(a2), .b(b2), .count(cnt2), .full(full2),
        .empty(empty2), .enter_pulse(ep2), .exit_pulse(xp2), .overflow(ov2), .underflow(un2));

    always #5 clk = ~clk;

    task automatic gate_step(input int dir, input int dep, input logic sa, input logic sb,
                             output int ndir, output int ndep, output int ev);
        logic p, q;
        ndir = dir; ndep = dep; ev = 0;
        if (dir == 3) begin
            if (!sa && !sb) ndir = 0;
        end else if (dir == 0) begin
            if (sa && !sb)      begin ndir = 1; ndep = 1; end
            else if (!sa && sb) begin ndir = 2; ndep = 1; end
            else if (sa && sb)  ndir = 3;
        end else begin
            // exit path is the entry path with the sensors swapped
            p = (dir == 1) ? sa : sb;
            q = (dir == 1) ? sb : sa;
            case (dep)
                1: if (p && q) ndep = 2; else if (!p && !q) ndir = 0; else if (!p && q) ndir = 3;
                2: if (!p && q) ndep = 3; else if (p && !q) ndep = 1; else if (!p && !q) ndir = 0;
                default: if (!p && !q) begin ndir = 0; ev = dir; end
                         else if (p && q) ndep = 2;
                         else if (p && !q) ndir = 3;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int g = 0; g < 4; g++) begin mdir[d][g] = 0; mdep[d][g] = 0; end
            mcount[d] = 0; ment[d] = '0; mext[d] = '0; mov[d] = 1'b0; mun[d] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            int ne, nx, nxt, nd, np, ev;
            logic sa, sb;
            ne = 0; nx = 0;
            ment[d] = '0; mext[d] = '0; mov[d] = 1'b0; mun[d] = 1'b0;
            for (int g = 0; g < ng[d]; g++) begin
                sa = (d == 0) ? a4[g] : a2[g];
                sb = (d == 0) ? b4[g] : b2[g];
                gate_step(mdir[d][g], mdep[d][g], sa, sb, nd, np, ev);
                mdir[d][g] = nd; mdep[d][g] = np;
                if (ev == 1) begin ne++; ment[d][g] = 1'b1; end
                if (ev == 2) begin nx++; mext[d][g] = 1'b1; end
            end
            nxt = mcount[d] + ne - nx;
            if (nxt > cap[d])  begin mcount[d] = cap[d]; mov[d] = 1'b1; end
            else if (nxt < 0)  begin mcount[d] = 0; mun[d] = 1'b1; end
            else               mcount[d] = nxt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_update();
        #1;
    endtask

    task automatic do_reset();
        a4 = '0; b4 = '0; a2 = '0; b2 = '0;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic seq4(input int g, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3);
        {a4[g], b4[g]} = s0; step();
        {a4[g], b4[g]} = s1; step();
        {a4[g], b4[g]} = s2; step();
        {a4[g], b4[g]} = s3; step();
    endtask

    task automatic seq2(input int g, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3);
        {a2[g], b2[g]} = s0; step();
        {a2[g], b2[g]} = s1; step();
        {a2[g], b2[g]} = s2; step();
        {a2[g], b2[g]} = s3; step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cnt4 !== 8'd0)   begin bad++; $display("FAIL reset_count4 got=%0d exp=0", cnt4); end
        total++; if (empty4 !== 1'b1 || full4 !== 1'b0) begin bad++; $display("FAIL reset_flags4 got empty=%b full=%b exp 1/0", empty4, full4); end
        total++; if ({ep4, xp4, ov4, un4} !== 10'd0) begin bad++; $display("FAIL reset_pulses4 got=%b exp=0", {ep4, xp4, ov4, un4}); end
        total++; if (cnt2 !== 4'd0 || empty2 !== 1'b1 || full2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 got cnt=%0d empty=%b full=%b exp 0/1/0", cnt2, empty2, full2); end
    endtask

    task automatic test_entry();
        {a4[0], b4[0]} = 2'b10; step();
        {a4[0], b4[0]} = 2'b11; step();
        {a4[0], b4[0]} = 2'b01; step();
        total++; if (ep4 !== 4'b0000 || cnt4 !== 8'd0) begin bad++; $display("FAIL entry_early got ep=%b cnt=%0d exp 0000/0", ep4, cnt4); end
        {a4[0], b4[0]} = 2'b00; step();
        total++; if (ep4 !== 4'b0001) begin bad++; $display("FAIL entry_pulse got=%b exp=0001", ep4); end
        total++; if (cnt4 !== 8'd1 || empty4 !== 1'b0) begin bad++; $display("FAIL entry_count got cnt=%0d empty=%b exp 1/0", cnt4, empty4); end
        step();
        total++; if (ep4 !== 4'b0000) begin bad++; $display("FAIL entry_pulse_width got=%b exp=0000", ep4); end
    endtask

    task automatic test_exit_abort();
        seq4(0, 2'b10, 2'b11, 2'b01, 2'b00);
        seq4(0, 2'b10, 2'b11, 2'b01, 2'b00);
        total++; if (cnt4 !== 8'd3) begin bad++; $display("FAIL exit_setup got=%0d exp=3", cnt4); end
        seq4(1, 2'b01, 2'b11, 2'b10, 2'b00);
        total++; if (xp4 !== 4'b0010 || cnt4 !== 8'd2) begin bad++; $display("FAIL exit_pulse got xp=%b cnt=%0d exp 0010/2", xp4, cnt4); end
        {a4[1], b4[1]} = 2'b10; step();
        {a4[1], b4[1]} = 2'b00; step();
        total++; if ({ep4, xp4} !== 8'd0 || cnt4 !== 8'd2) begin bad++; $display("FAIL abort got ep=%b xp=%b cnt=%0d exp 0/0/2", ep4, xp4, cnt4); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) seq4(3, 2'b10, 2'b11, 2'b01, 2'b00);
        total++; if (cnt4 !== 8'd5) begin bad++; $display("FAIL simul_setup got=%0d exp=5", cnt4); end
        a4 = 4'b0011; b4 = 4'b0100; step();
        a4 = 4'b0111; b4 = 4'b0111; step();
        a4 = 4'b0100; b4 = 4'b0011; step();
        a4 = 4'b0000; b4 = 4'b0000; step();
        total++; if (ep4 !== 4'b0011 || xp4 !== 4'b0100) begin bad++; $display("FAIL simul_pulses got ep=%b xp=%b exp 0011/0100", ep4, xp4); end
        total++; if (cnt4 !== 8'd6 || ov4 !== 1'b0 || un4 !== 1'b0) begin bad++; $display("FAIL simul_count got cnt=%0d ov=%b un=%b exp 6/0/0", cnt4, ov4, un4); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) seq2(0, 2'b10, 2'b11, 2'b01, 2'b00);
        total++; if (cnt2 !== 4'd3 || full2 !== 1'b1) begin bad++; $display("FAIL sat_full got cnt=%0d full=%b exp 3/1", cnt2, full2); end
        seq2(1, 2'b10, 2'b11, 2'b01, 2'b00);
        total++; if (ep2 !== 2'b10 || ov2 !== 1'b1 || cnt2 !== 4'd3) begin bad++; $display("FAIL sat_overflow got ep=%b ov=%b cnt=%0d exp 10/1/3", ep2, ov2, cnt2); end
        step();
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL sat_ov_width got=%b exp=0", ov2); end
        a2 = 2'b01; b2 = 2'b10; step();
        a2 = 2'b11; b2 = 2'b11; step();
        a2 = 2'b10; b2 = 2'b01; step();
        a2 = 2'b00; b2 = 2'b00; step();
        total++; if (ep2 !== 2'b01 || xp2 !== 2'b10 || ov2 !== 1'b0 || cnt2 !== 4'd3) begin bad++; $display("FAIL sat_net got ep=%b xp=%b ov=%b cnt=%0d exp 01/10/0/3", ep2, xp2, ov2, cnt2); end
    endtask

    task automatic test_underflow();
        do_reset();
        seq2(0, 2'b01, 2'b11, 2'b10, 2'b00);
        total++; if (xp2 !== 2'b01 || un2 !== 1'b1) begin bad++; $display("FAIL underflow_pulse got xp=%b un=%b exp 01/1", xp2, un2); end
        total++; if (cnt2 !== 4'd0 || empty2 !== 1'b1) begin bad++; $display("FAIL underflow_count got cnt=%0d empty=%b exp 0/1", cnt2, empty2); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) seq4(2, 2'b10, 2'b11, 2'b01, 2'b00);
        total++; if (cnt4 !== 8'd7) begin bad++; $display("FAIL rmid_setup got=%0d exp=7", cnt4); end
        {a4[0], b4[0]} = 2'b10; step();
        {a4[0], b4[0]} = 2'b11; step();
        {a4[0], b4[0]} = 2'b01; step();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        total++; if (cnt4 !== 8'd0 || empty4 !== 1'b1 || full4 !== 1'b0) begin bad++; $display("FAIL rmid_async got cnt=%0d empty=%b full=%b exp 0/1/0", cnt4, empty4, full4); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        {a4[0], b4[0]} = 2'b00; step();
        total++; if ({ep4, xp4} !== 8'd0 || cnt4 !== 8'd0) begin bad++; $display("FAIL rmid_resume got ep=%b xp=%b cnt=%0d exp 0/0/0", ep4, xp4, cnt4); end
        // second pass releases with sensors clear, so a stale E3 would show as an entry
        {a4[0], b4[0]} = 2'b10; step();
        {a4[0], b4[0]} = 2'b11; step();
        {a4[0], b4[0]} = 2'b01; step();
        #2 reset_n = 1'b0;
        model_reset();
        {a4[0], b4[0]} = 2'b00;
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        total++; if (ep4 !== 4'b0000 || cnt4 !== 8'd0) begin bad++; $display("FAIL rmid_clear got ep=%b cnt=%0d exp 0000/0", ep4, cnt4); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int g = 0; g < 4; g++)
                if ($urandom_range(0, 1) == 0) {a4[g], b4[g]} = 2'($urandom_range(0, 3));
            for (int g = 0; g < 2; g++)
                if ($urandom_range(0, 1) == 0) {a2[g], b2[g]} = 2'($urandom_range(0, 3));
            step();
            total++;
            if (cnt4 !== 8'(mcount[0]) || ep4 !== ment[0] || xp4 !== mext[0] || ov4 !== mov[0] ||
                un4 !== mun[0] || full4 !== (mcount[0] == cap[0]) || empty4 !== (mcount[0] == 0)) begin
                bad++;
                if (errs++ < 10) $display("FAIL rand_dut4 cyc=%0d got cnt=%0d ep=%b xp=%b ov=%b un=%b exp cnt=%0d ep=%b xp=%b ov=%b un=%b",
                    c, cnt4, ep4, xp4, ov4, un4, mcount[0], ment[0], mext[0], mov[0], mun[0]);
            end
            total++;
            if (cnt2 !== 4'(mcount[1]) || ep2 !== ment[1][1:0] || xp2 !== mext[1][1:0] || ov2 !== mov[1] ||
                un2 !== mun[1] || full2 !== (mcount[1] == cap[1]) || empty2 !== (mcount[1] == 0)) begin
                bad++;
                if (errs++ < 10) $display("FAIL rand_dut2 cyc=%0d got cnt=%0d ep=%b xp=%b ov=%b un=%b exp cnt=%0d ep=%b xp=%b ov=%b un=%b",
                    c, cnt2, ep2, xp2, ov2, un2, mcount[1], ment[1][1:0], mext[1][1:0], mov[1], mun[1]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_entry();
        test_exit_abort();
        test_simultaneous();
        test_saturation();
        test_underflow();
        test_reset_mid();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_ctrl.md
# parking_occupancy_ctrl

Multi-gate parking lot occupancy controller: generalises the single-gate entry/exit counter to `GATES` independent two-sensor gates sharing one occupancy count with a programmable capacity. Each gate runs its own direction-detecting FSM on debounced sensor levels. Per-cycle entry and exit events from all gates are summed into a saturating occupancy register with full, empty, overflow and underflow reporting. The block sits between the per-sensor debouncers and the binary-to-BCD / seven-segment display path.

## Interface
- `GATES`, 2: number of gates, 1..8.
- `CAP_BITS`, 8: width of the occupancy count.
- `CAPACITY`, 200: maximum occupancy, 1..2^CAP_BITS-1.
- `clk` in 1: system clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `a` in GATES: debounced outer sensor per gate, level, 1 = blocked.
- `b` in GATES: debounced inner sensor per gate, level, 1 = blocked.
- `count` out CAP_BITS: current occupancy, registered.
- `full` out 1: `count == CAPACITY`.
- `empty` out 1: `count == 0`.
- `enter_pulse` out GATES: one-cycle pulse per completed entry.
- `exit_pulse` out GATES: one-cycle pulse per completed exit.
- `overflow` out 1: one-cycle pulse when the unclamped next count exceeds `CAPACITY`.
- `underflow` out 1: one-cycle pulse when the unclamped next count is below 0.

## Operation
- Each gate has an independent FSM on the sample `{a[g],b[g]}`.
  - States: IDLE, E1, E2, E3, X1, X2, X3, WAIT.
  - Any sample not listed below holds the current state.
- Transitions from IDLE:
  - 10 -> E1.
  - 01 -> X1.
  - 11 -> WAIT.
- Entry path:
  - E1: 11 -> E2; 00 -> IDLE (abort); 01 -> WAIT.
  - E2: 01 -> E3; 10 -> E1; 00 -> IDLE (no event).
  - E3: 00 -> IDLE with `enter_pulse[g]`; 11 -> E2; 10 -> WAIT.
- Exit path:
  - Mirrors the entry path with `a` and `b` swapped.
  - X3 with sample 00 -> IDLE with `exit_pulse[g]`.
- WAIT: 00 -> IDLE, no event. Used for illegal or ambiguous sequences.
- Count arithmetic:
  - Each cycle, next = count + popcount(enter) - popcount(exit).
  - Compute in a signed intermediate of CAP_BITS+2 bits.
  - Clamp the result to [0, CAPACITY].
  - Unclamped next > CAPACITY: count = CAPACITY, `overflow` pulses.
  - Unclamped next < 0: count = 0, `underflow` pulses.
  - Events are never queued; excess is dropped after reporting.
- Simultaneous events:
  - Entries and exits on any gates in the same cycle net out before clamping.
  - Example: count = CAPACITY with one entry and one exit in the same cycle gives count unchanged and no overflow.
- Gates cannot interfere: a gate's FSM depends only on its own `a` and `b`.

## Timing
- Sensor sample at edge N moves FSM state, and registers the `enter_pulse`/`exit_pulse`, `count`, `overflow` and `underflow` updates, at edge N.
- Pulses are high for exactly the one cycle following edge N.
- `count` shows the new value in that same cycle.
- `full` and `empty` are combinational from registered `count`, so they are always consistent with it.
- Sensor-to-count latency is 1 clock edge.
- Minimum full entry is 4 samples (10, 11, 01, 00): one per cycle after IDLE.
- Reset (`reset_n` = 0, any time, including mid-sequence) forces:
  - all FSMs to IDLE;
  - `count` = 0;
  - all pulses, `overflow` and `underflow` = 0;
  - therefore `empty` = 1, `full` = 0.
- After reset is released, a gate whose sensors are already blocked follows the IDLE transitions.
  - A car caught mid-gate therefore resolves to WAIT or a partial sequence and is never counted twice.

## Test plan
- Gate 0 entry: `a`/`b` = 10, 11, 01, 00 on successive cycles from reset. Expect `enter_pulse[0]` = 1 for one cycle, `count` 0 -> 1, `empty` drops.
- Gate 1 exit then abort: from `count` = 3, send 01, 11, 10, 00 (count 2); then send 10, 00. Expect no pulse and `count` = 2.
- Simultaneous gates with `GATES` = 4 and `count` = 5: in one cycle gates 0 and 1 complete entries while gate 2 completes an exit. Expect `count` = 6 and three pulses in the same cycle.
- Saturation with `CAPACITY` = 3:
  - 3 entries give `full` = 1.
  - A 4th entry gives `enter_pulse` and `overflow` high, `count` = 3.
  - An entry and an exit in the same cycle at full give `count` = 3 and no overflow.
- Underflow: an exit completes at `count` = 0. Expect `exit_pulse` and `underflow` high, `count` = 0.
- Reset mid-sequence: assert `reset_n` = 0 in E3 with `count` = 7. Expect `count` = 0 and FSM in IDLE immediately. After release with sensors at 01 then 00, expect no `enter_pulse` (X1 then IDLE, no event).
